// File: rtl/mem_dma_copy.sv
// Bus initiator for a single-port word-addressed memory: sequential COPY (read/write
// alternation) and FILL (constant pattern) over a wrapping destination range.
module mem_dma_copy #(
   parameter int unsigned AW = 8,
   parameter int unsigned DW = 64,
   parameter int unsigned LW = 9   // must be >= AW+1 so a full 2^AW transfer fits
) (
   input  logic          clk,
   input  logic          rst,
   input  logic          start,
   input  logic          mode,
   input  logic [AW-1:0] src,
   input  logic [AW-1:0] dst,
   input  logic [LW-1:0] len,
   input  logic [DW-1:0] pattern,
   input  logic          abort,
   output logic          busy,
   output logic          done,
   output logic [LW-1:0] words_done,
   output logic [AW-1:0] mem_addr,
   output logic [DW-1:0] mem_write_data,
   output logic          mem_write_enable,
   input  logic [DW-1:0] mem_read_data
);

   typedef enum logic [2:0] {
      IDLE,
      RD,
      WR,
      FILL,
      DONE
   } state_t;

   state_t        state;
   state_t        state_next;
   logic [AW-1:0] src_cur;
   logic [AW-1:0] dst_cur;
   logic [LW-1:0] remaining;
   logic [DW-1:0] pattern_q;
   logic          last_word;
   logic          accept;

   assign accept    = (state == IDLE) && start;
   assign last_word = (remaining == LW'(1));

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state <= IDLE;
      end else begin
         state <= state_next;
      end
   end

   always_comb begin
      state_next = state;
      unique case (state)
         IDLE: begin
            if (start) begin
               if (len == '0) begin
                  state_next = DONE;
               end else if (mode) begin
                  state_next = FILL;
               end else begin
                  state_next = RD;
               end
            end
         end
         RD: begin
            state_next = abort ? IDLE : WR;
         end
         WR: begin
            if (abort) begin
               state_next = IDLE;
            end else if (last_word) begin
               state_next = DONE;
            end else begin
               state_next = RD;
            end
         end
         FILL: begin
            if (abort) begin
               state_next = IDLE;
            end else if (last_word) begin
               state_next = DONE;
            end
         end
         DONE: begin
            state_next = IDLE;
         end
         default: begin
            state_next = IDLE;
         end
      endcase
   end

   // A write cycle always completes its counter updates, even when aborted.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         src_cur    <= '0;
         dst_cur    <= '0;
         remaining  <= '0;
         pattern_q  <= '0;
         words_done <= '0;
      end else if (accept) begin
         src_cur    <= src;
         dst_cur    <= dst;
         remaining  <= len;
         pattern_q  <= pattern;
         words_done <= '0;
      end else if (state == WR) begin
         src_cur    <= src_cur + AW'(1);
         dst_cur    <= dst_cur + AW'(1);
         remaining  <= remaining - LW'(1);
         words_done <= words_done + LW'(1);
      end else if (state == FILL) begin
         dst_cur    <= dst_cur + AW'(1);
         remaining  <= remaining - LW'(1);
         words_done <= words_done + LW'(1);
      end
   end

   always_comb begin
      busy             = 1'b0;
      done             = 1'b0;
      mem_addr         = '0;
      mem_write_data   = '0;
      mem_write_enable = 1'b0;
      unique case (state)
         RD: begin
            busy     = 1'b1;
            mem_addr = src_cur;
         end
         WR: begin
            busy             = 1'b1;
            mem_addr         = dst_cur;
            mem_write_data   = mem_read_data;
            mem_write_enable = 1'b1;
         end
         FILL: begin
            busy             = 1'b1;
            mem_addr         = dst_cur;
            mem_write_data   = pattern_q;
            mem_write_enable = 1'b1;
         end
         DONE: begin
            done = 1'b1;
         end
         default: begin
         end
      endcase
   end

endmodule

// File: tb/tb_mem_dma_copy.sv
// Randomized bench for mem_dma_copy: a memory model answers the bus, and a sequential
// word-by-word reference predicts per-cycle bus activity, flags and final contents.
module tb_mem_dma_copy;

   logic        clk = 1'b0;
   logic        rst;
   logic        start;
   logic        mode;
   logic [7:0]  src;
   logic [7:0]  dst;
   logic [8:0]  len;
   logic [63:0] pattern;
   logic        abort;
   logic        busy;
   logic        done;
   logic [8:0]  words_done;
   logic [7:0]  mem_addr;
   logic [63:0] mem_write_data;
   logic        mem_write_enable;
   logic [63:0] mem_read_data;

   logic [63:0] mem  [256];
   logic [63:0] gold [256];

   int checks   = 0;
   int failures = 0;

   mem_dma_copy #(.AW(8), .DW(64), .LW(9)) dut (
      .clk(clk),
      .rst(rst),
      .start(start),
      .mode(mode),
      .src(src),
      .dst(dst),
      .len(len),
      .pattern(pattern),
      .abort(abort),
      .busy(busy),
      .done(done),
      .words_done(words_done),
      .mem_addr(mem_addr),
      .mem_write_data(mem_write_data),
      .mem_write_enable(mem_write_enable),
      .mem_read_data(mem_read_data)
   );

   always #5 clk = ~clk;

   always @(posedge clk) begin
      mem_read_data <= mem[mem_addr];
      if (mem_write_enable) mem[mem_addr] <= mem_write_data;
   end

   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
      checks++;
      if (got !== exp) begin
         failures++;
         $display("FAIL %s got=%h exp=%h", tag, got, exp);
      end
   endtask

   task automatic preload(input int a, input logic [63:0] v);
      mem[a]  = v;
      gold[a] = v;
   endtask

   task automatic check_idle_outputs(input string tag);
      check({tag, " busy"}, 64'(busy), 64'd0);
      check({tag, " done"}, 64'(done), 64'd0);
      check({tag, " words_done"}, 64'(words_done), 64'd0);
      check({tag, " mem_addr"}, 64'(mem_addr), 64'd0);
      check({tag, " mem_wdata"}, mem_write_data, 64'd0);
      check({tag, " mem_we"}, 64'(mem_write_enable), 64'd0);
   endtask

   // abort_at / rst_at: cycle (1 = first after the start edge) in which abort is held
   // or reset is asserted; 0 disables.
   task automatic run_op(input bit m, input logic [7:0] s, input logic [7:0] d,
                         input logic [8:0] n, input logic [63:0] p,
                         input int abort_at, input int rst_at,
                         input bit noise, input bit abort_with_start);
      int period, busy_end, done_cyc, last, stop, widx;
      int          wcyc  [$];
      logic [7:0]  waddr [$];
      logic [63:0] wdata [$];
      logic [63:0] dat;
      bit          exp_we;
      string       tag;

      period   = m ? 1 : 2;
      busy_end = period * int'(n);
      done_cyc = (abort_at > 0 || rst_at > 0) ? 0 : busy_end + 1;
      if (abort_at > 0) busy_end = abort_at;
      last = (abort_at > 0) ? abort_at : ((rst_at > 0) ? rst_at - 1 : busy_end);

      for (int i = 0; i < int'(n); i++) begin
         if (period * (i + 1) > last) break;
         dat = m ? p : gold[8'(int'(s) + i)];
         gold[8'(int'(d) + i)] = dat;
         wcyc.push_back(period * (i + 1));
         waddr.push_back(8'(int'(d) + i));
         wdata.push_back(dat);
      end

      @(negedge clk);
      mode = m; src = s; dst = d; len = n; pattern = p;
      start = 1'b1;
      abort = abort_with_start;
      @(negedge clk);
      start = 1'b0;
      abort = 1'b0;

      stop = (rst_at > 0) ? rst_at : ((done_cyc > 0) ? done_cyc : busy_end + 1);
      widx = 0;
      for (int k = 1; k <= stop; k++) begin
         if (k > 1) @(negedge clk);
         if (rst_at > 0 && k == rst_at) begin
            #1 rst = 1'b1;
            #1 check_idle_outputs("reset_mid");
            @(negedge clk);
            rst = 1'b0;
            break;
         end
         tag    = $sformatf("m%0d n%0d c%0d", m, n, k);
         exp_we = (widx < wcyc.size()) && (wcyc[widx] == k);
         check({tag, " busy"}, 64'(busy), 64'(k <= busy_end));
         check({tag, " done"}, 64'(done), 64'(k == done_cyc));
         check({tag, " words_done"}, 64'(words_done), 64'(widx));
         check({tag, " we"}, 64'(mem_write_enable), 64'(exp_we));
         if (exp_we) begin
            check({tag, " waddr"}, 64'(mem_addr), 64'(waddr[widx]));
            check({tag, " wdata"}, mem_write_data, wdata[widx]);
            widx++;
         end else if (k > busy_end) begin
            check({tag, " addr_idle"}, 64'(mem_addr), 64'd0);
            check({tag, " wdata_idle"}, mem_write_data, 64'd0);
         end
         abort = (k == abort_at) || (noise && k == done_cyc);
         start = (noise && k <= busy_end) ? 1'($urandom_range(0, 1)) : 1'b0;
      end
      start = 1'b0;
      abort = 1'b0;

      for (int i = 0; i < 256; i++) begin
         if (mem[i] !== gold[i]) check($sformatf("mem[%02h]", i), mem[i], gold[i]);
      end
      check($sformatf("mem_ok m%0d n%0d", m, n), 64'd1, 64'd1);
   endtask

   initial begin
      #2_000_000;
      $display("FAIL watchdog timeout");
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures + 1);
      $fatal(1);
   end

   initial begin
      int          nn, per, ab, rs;
      bit          mm;
      logic [63:0] pp;

      rst = 1'b1; start = 1'b0; mode = 1'b0; src = '0; dst = '0; len = '0;
      pattern = '0; abort = 1'b0;
      for (int i = 0; i < 256; i++) preload(i, {$urandom, $urandom});
      #1 check_idle_outputs("reset");
      repeat (2) @(negedge clk);
      rst = 1'b0;

      // Reset mid-FILL after three writes
      run_op(1'b1, 8'h00, 8'h40, 9'd10, 64'h1234_5678_9ABC_DEF0, 0, 4, 1'b0, 1'b0);
      // COPY with start noise while busy
      preload(8'h10, 64'hA); preload(8'h11, 64'hB); preload(8'h12, 64'hC); preload(8'h13, 64'hD);
      run_op(1'b0, 8'h10, 8'h80, 9'd4, 64'h0, 0, 0, 1'b1, 1'b0);
      check("copy_result", mem[8'h83], 64'hD);
      // FILL wrapping past 0xFF
      run_op(1'b1, 8'h00, 8'hFE, 9'd4, 64'hDEAD_BEEF, 0, 0, 1'b0, 1'b0);
      check("fill_wrap", mem[8'h01], 64'hDEAD_BEEF);
      // Zero length, with abort alongside start
      run_op(1'b0, 8'h33, 8'h44, 9'd0, 64'h0, 0, 0, 1'b1, 1'b1);
      // Overlapping forward copy
      preload(8'h20, 64'h5); preload(8'h21, 64'h0); preload(8'h22, 64'h0); preload(8'h23, 64'h0);
      run_op(1'b0, 8'h20, 8'h21, 9'd3, 64'h0, 0, 0, 1'b0, 1'b0);
      check("overlap", mem[8'h23], 64'h5);
      // Abort in the third WR cycle
      run_op(1'b0, 8'h50, 8'hA0, 9'd8, 64'h0, 6, 0, 1'b0, 1'b0);
      // Full-range and over-length transfers
      run_op(1'b1, 8'h00, 8'h10, 9'd256, 64'hCAFE, 0, 0, 1'b0, 1'b0);
      run_op(1'b0, 8'h05, 8'h90, 9'd300, 64'h0, 0, 0, 1'b0, 1'b0);

      for (int t = 0; t < 40; t++) begin
         mm = 1'($urandom_range(0, 1));
         nn = ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, 300))
                                          : int'($urandom_range(0, 12));
         per = mm ? 1 : 2;
         pp  = {$urandom, $urandom};
         ab  = 0;
         rs  = 0;
         if (nn > 0 && $urandom_range(0, 3) == 0) begin
            ab = int'($urandom_range(1, per * nn));
         end else if (nn > 0 && $urandom_range(0, 9) == 0) begin
            rs = int'($urandom_range(1, per * nn));
         end
         run_op(mm, 8'($urandom), 8'($urandom), 9'(nn), pp, ab, rs,
                1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
      end

      repeat (2) @(negedge clk);
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/mem_dma_copy.md
Name: mem_dma_copy

Overview:
- Bus initiator for the 256 x 64-bit single-port memory. Issues the address, write-data and write-enable sequences the memory expects.
- Captures the memory's registered read data, which is valid the cycle after the address is presented.
- Supports two operations:
  - COPY: block copy from a source range to a destination range.
  - FILL: writes a constant pattern across a destination range.
- Sits between control logic (CPU/test harness) and the memory. It is the memory's only master while busy.

Parameters:
AW, 8, memory address width (word-addressed)
DW, 64, memory data width
LW, 9, length field width; must be >= AW+1 so a full 2^AW-word transfer is expressible

Ports:
clk  input  1  system clock, all state on rising edge
rst  input  1  asynchronous, active-high reset
start  input  1  request; sampled only when idle
mode  input  1  0 = COPY, 1 = FILL; latched at start
src  input  AW  COPY source base address; latched at start
dst  input  AW  destination base address; latched at start
len  input  LW  word count; latched at start
pattern  input  DW  FILL data; latched at start
abort  input  1  terminate the current transfer
busy  output  1  transfer in progress
done  output  1  one-cycle pulse on normal completion
words_done  output  LW  destination words written in the current/last transfer
mem_addr  output  AW  memory address
mem_write_data  output  DW  memory write data
mem_write_enable  output  1  memory write strobe
mem_read_data  input  DW  memory read data, valid the cycle after mem_addr is presented

Behaviour:
- Reset (async, rst=1): state IDLE, busy=0, done=0, words_done=0, mem_addr=0, mem_write_data=0, mem_write_enable=0.
  - Reset mid-transfer abandons it: no done pulse, no further writes.
- States: IDLE, RD, WR, FILL, DONE. Memory outputs are decoded from state registers.
- Outside RD/WR/FILL: mem_addr=0, mem_write_data=0, mem_write_enable=0.
- IDLE:
  - start=1 at an edge latches mode/src/dst/len/pattern and clears words_done.
  - len=0 goes to DONE; otherwise COPY goes to RD and FILL goes to FILL.
  - start is ignored in every other state.
- RD: mem_addr=src_cur, mem_write_enable=0. Next state WR.
- WR:
  - Drives mem_addr=dst_cur, mem_write_enable=1, mem_write_data=mem_read_data (direct pass-through of the memory's registered output).
  - At the edge: src_cur++, dst_cur++, words_done++, remaining--. Next state is RD, or DONE when remaining reaches 0.
- FILL:
  - Drives mem_addr=dst_cur, mem_write_enable=1, mem_write_data=pattern.
  - At the edge: dst_cur++, words_done++, remaining--. Stays in FILL until remaining reaches 0, then DONE.
- DONE: done=1 for exactly one cycle, busy=0, then IDLE.
- busy=1 exactly in RD, WR and FILL.
- Latency from the start edge:
  - COPY of N words: busy for cycles 1..2N, done in cycle 2N+1.
  - FILL of N words: busy for cycles 1..N, done in cycle N+1.
  - len=0: done in cycle 1, busy never asserted.
  - A new start is accepted in the cycle after done.
- Address arithmetic: src_cur and dst_cur increment modulo 2^AW. 255 wraps to 0 with no error.
- Length: len > 2^AW is legal; it wraps and rewrites addresses.
- Overlap: the result is defined as a strictly sequential forward word-by-word copy. Each word is read immediately before it is written, with no overlap correction.
  - Example: with dst = src+1, the word at src propagates through the whole range.
- abort:
  - When sampled high while busy, the current cycle's memory access still completes, including a WR/FILL write in that cycle.
  - The next state is IDLE, with no done pulse. words_done holds the count including that final write.
  - abort is ignored in IDLE and DONE.
- abort and start high together in IDLE: start wins.
- words_done holds its value after completion or abort until the next accepted start.

Test Plan:
- Reset: assert rst mid-FILL (len=10, after 3 writes) -> outputs zero immediately, no done, memory addresses dst+3..dst+9 unwritten.
- COPY: preload mem[0x10..0x13]=0xA,0xB,0xC,0xD; start src=0x10, dst=0x80, len=4 -> RD/WR alternate, busy cycles 1..8, done in cycle 9; mem[0x80..0x83]=0xA..0xD; words_done=4.
- FILL with wrap: dst=0xFE, len=4, pattern=0xDEAD_BEEF -> writes 0xFE, 0xFF, 0x00, 0x01 in cycles 1..4; done in cycle 5.
- len=0 start -> done in cycle 1, mem_write_enable never asserted, words_done=0; start asserted during a busy COPY -> ignored, COPY result unchanged.
- Overlap: mem[0x20]=0x5, mem[0x21..0x23]=0; COPY src=0x20, dst=0x21, len=3 -> mem[0x21..0x23]=0x5.
- Abort: COPY len=8, abort asserted in the third WR cycle -> write of word 2 occurs, IDLE next cycle, done never pulses, words_done=3.
